// File: rtl/data_line_sequencer.sv
// Data line sequencer: owns the tape pointer, caches the current cell with a
// dirty flag and orders RAM write-back/read around pointer moves.
// Ports: i_clock/i_rst (sync, active-low); command handshake i_cmd_valid/i_cmd/
// o_cmd_ready/o_done; RAM side o_address/o_mem_rd/o_mem_wr/o_mem_wdata/
// i_mem_rdata; o_cell/o_zero for loop control; console o_out_*/i_out_ready and
// o_in_ready/i_in_valid/i_in_data.
module data_line_sequencer #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int MAX_ADDRESS   = 29999,
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_DATA      = 255
) (
  input  logic                     i_clock,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  input  logic [2:0]               i_cmd,
  output logic                     o_cmd_ready,
  output logic                     o_done,
  output logic [ADDRESS_WIDTH-1:0] o_address,
  output logic                     o_mem_rd,
  output logic                     o_mem_wr,
  output logic [DATA_WIDTH-1:0]    o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]    i_mem_rdata,
  output logic [DATA_WIDTH-1:0]    o_cell,
  output logic                     o_zero,
  output logic                     o_out_valid,
  output logic [DATA_WIDTH-1:0]    o_out_data,
  input  logic                     i_out_ready,
  output logic                     o_in_ready,
  input  logic                     i_in_valid,
  input  logic [DATA_WIDTH-1:0]    i_in_data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WB   = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_OUTW = 3'd4,
    S_INW  = 3'd5
  } state_t;

  localparam logic [2:0] C_NOP   = 3'd0;
  localparam logic [2:0] C_INC   = 3'd1;
  localparam logic [2:0] C_DEC   = 3'd2;
  localparam logic [2:0] C_RIGHT = 3'd3;
  localparam logic [2:0] C_LEFT  = 3'd4;
  localparam logic [2:0] C_OUT   = 3'd5;
  localparam logic [2:0] C_IN    = 3'd6;
  localparam logic [2:0] C_FLUSH = 3'd7;

  localparam logic [ADDRESS_WIDTH-1:0] LP_MAX_ADDR = ADDRESS_WIDTH'(MAX_ADDRESS);
  localparam logic [DATA_WIDTH-1:0]    LP_MAX_DATA = DATA_WIDTH'(MAX_DATA);

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic [ADDRESS_WIDTH-1:0] r_pend_addr;  // target pointer held across WB
  logic [DATA_WIDTH-1:0]    r_cell;
  logic                     r_dirty;
  logic                     r_cmd_ready;
  logic                     r_done;
  logic                     r_mem_rd;
  logic                     r_mem_wr;
  logic [DATA_WIDTH-1:0]    r_mem_wdata;
  logic                     r_out_valid;
  logic [DATA_WIDTH-1:0]    r_out_data;
  logic                     r_in_ready;
  logic                     r_flush;      // WB belongs to a FLUSH, not a move
  logic                     r_cmd_act;    // RD/CAP serve a command, so CAP retires it

  logic                     w_accept;
  logic [ADDRESS_WIDTH-1:0] w_addr_next;
  logic [DATA_WIDTH-1:0]    w_cell_inc;
  logic [DATA_WIDTH-1:0]    w_cell_dec;

  assign w_accept   = i_cmd_valid & r_cmd_ready;
  assign w_cell_inc = (r_cell == LP_MAX_DATA) ? '0 : r_cell + 1'b1;
  assign w_cell_dec = (r_cell == '0) ? LP_MAX_DATA : r_cell - 1'b1;

  always_comb begin
    w_addr_next = r_address;
    if (i_cmd == C_RIGHT) begin
      w_addr_next = (r_address == LP_MAX_ADDR) ? '0 : r_address + 1'b1;
    end else if (i_cmd == C_LEFT) begin
      w_addr_next = (r_address == '0) ? LP_MAX_ADDR : r_address - 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_rst) begin
      r_state     <= S_RD;
      r_address   <= '0;
      r_pend_addr <= '0;
      r_cell      <= '0;
      r_dirty     <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_done      <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_wdata <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_in_ready  <= 1'b0;
      r_flush     <= 1'b0;
      r_cmd_act   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (i_cmd)
              C_NOP: r_done <= 1'b1;
              C_INC: begin
                r_cell  <= w_cell_inc;
                r_dirty <= 1'b1;
                r_done  <= 1'b1;
              end
              C_DEC: begin
                r_cell  <= w_cell_dec;
                r_dirty <= 1'b1;
                r_done  <= 1'b1;
              end
              C_RIGHT, C_LEFT: begin
                r_cmd_ready <= 1'b0;
                r_cmd_act   <= 1'b1;
                r_pend_addr <= w_addr_next;
                if (r_dirty) begin
                  // write the cached cell back at the old pointer first
                  r_mem_wr    <= 1'b1;
                  r_mem_wdata <= r_cell;
                  r_flush     <= 1'b0;
                  r_state     <= S_WB;
                end else begin
                  r_address <= w_addr_next;
                  r_mem_rd  <= 1'b1;
                  r_state   <= S_RD;
                end
              end
              C_OUT: begin
                r_cmd_ready <= 1'b0;
                r_out_valid <= 1'b1;
                r_out_data  <= r_cell;
                r_state     <= S_OUTW;
              end
              C_IN: begin
                r_cmd_ready <= 1'b0;
                r_in_ready  <= 1'b1;
                r_state     <= S_INW;
              end
              default: begin  // FLUSH
                if (r_dirty) begin
                  r_cmd_ready <= 1'b0;
                  r_mem_wr    <= 1'b1;
                  r_mem_wdata <= r_cell;
                  r_flush     <= 1'b1;
                  r_state     <= S_WB;
                end else begin
                  r_done <= 1'b1;
                end
              end
            endcase
          end
        end
        S_WB: begin
          r_mem_wr <= 1'b0;
          r_dirty  <= 1'b0;
          if (r_flush) begin
            r_done      <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_address <= r_pend_addr;
            r_mem_rd  <= 1'b1;
            r_state   <= S_RD;
          end
        end
        S_RD: begin
          // Entered from reset with the strobe still low: raise it for one
          // cycle before moving on, so the reload read looks like any other.
          if (r_mem_rd) begin
            r_mem_rd <= 1'b0;
            r_state  <= S_CAP;
          end else begin
            r_mem_rd <= 1'b1;
          end
        end
        S_CAP: begin
          r_cell      <= i_mem_rdata;
          r_done      <= r_cmd_act;
          r_cmd_act   <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_OUTW: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_INW: begin
          if (i_in_valid) begin
            r_cell      <= i_in_data;
            r_dirty     <= 1'b1;
            r_in_ready  <= 1'b0;
            r_done      <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_RD;
      endcase
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_done      = r_done;
  assign o_address   = r_address;
  assign o_mem_rd    = r_mem_rd;
  // Qualified by reset so a reset landing on a WB cycle suppresses the write.
  assign o_mem_wr    = r_mem_wr & i_rst;
  assign o_mem_wdata = r_mem_wdata;
  assign o_cell      = r_cell;
  assign o_zero      = (r_cell == '0);
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_in_ready  = r_in_ready;

endmodule

// File: tb/tb_data_line_sequencer.sv
// Bench for data_line_sequencer: directed scenarios then random commands,
// checked against a tape-level model (array + pointer + dirty flag).
// Ports of the DUT are all driven/observed here; RAM is modelled locally.
module tb_data_line_sequencer;

  localparam int MAXA = 29999;

  bit          i_clock = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic [2:0]  i_cmd = 3'd0;
  logic        o_cmd_ready;
  logic        o_done;
  logic [15:0] o_address;
  logic        o_mem_rd;
  logic        o_mem_wr;
  logic [7:0]  o_mem_wdata;
  logic [7:0]  i_mem_rdata;
  logic [7:0]  o_cell;
  logic        o_zero;
  logic        o_out_valid;
  logic [7:0]  o_out_data;
  logic        i_out_ready = 1'b0;
  logic        o_in_ready;
  logic        i_in_valid = 1'b0;
  logic [7:0]  i_in_data = 8'd0;

  always #5 i_clock = ~i_clock;

  data_line_sequencer dut (
    .i_clock(i_clock), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .o_cmd_ready(o_cmd_ready), .o_done(o_done),
    .o_address(o_address), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .o_cell(o_cell), .o_zero(o_zero),
    .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ready(i_out_ready),
    .o_in_ready(o_in_ready), .i_in_valid(i_in_valid), .i_in_data(i_in_data)
  );

  // RAM: read data valid the cycle after the strobe
  logic [7:0] mem [0:MAXA];
  bit         ram_ready = 1'b0;
  always @(posedge i_clock) begin
    if (!ram_ready) begin
      for (int i = 0; i <= MAXA; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h41;
      mem[5] = 8'h07;
      ram_ready = 1'b1;
    end
    if (o_mem_rd) i_mem_rdata <= mem[o_address];
    if (o_mem_wr) mem[o_address] = o_mem_wdata;
  end

  // tape-level model
  logic [7:0] tape [0:MAXA];
  int         ptr;
  bit         dirty;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called in cycle 0 (first cycle with reset released). Re-syncs the model
  // from RAM, because dirty data is lost on reset.
  task automatic reset_release_check(input bit chk_41);
    int rd_at, rdy_at;
    bit done_seen;
    chk("rst_mem_rd", o_mem_rd, 0);
    chk("rst_mem_wr", o_mem_wr, 0);
    chk("rst_cmd_ready", o_cmd_ready, 0);
    chk("rst_address", o_address, 0);
    chk("rst_cell", o_cell, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_in_ready", o_in_ready, 0);
    rd_at = -1; rdy_at = -1; done_seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge i_clock); #1;
      if (o_mem_rd && rd_at < 0) begin
        rd_at = k;
        chk("reload_rd_addr", o_address, 0);
      end
      if (o_done) done_seen = 1'b1;
      if (o_cmd_ready) begin
        rdy_at = k;
        break;
      end
    end
    chk("reload_rd_cycle", rd_at, 1);
    chk("reload_ready_cycle", rdy_at, 3);
    chk("reload_no_done", done_seen, 0);
    for (int i = 0; i <= MAXA; i++) tape[i] = mem[i];
    ptr = 0;
    dirty = 1'b0;
    if (chk_41) chk("reload_cell_41", o_cell, 8'h41);
    chk("reload_cell", o_cell, tape[0]);
  endtask

  // Issue one command from IDLE and check it against the tape model.
  task automatic issue(input logic [2:0] c, input int out_wait,
                       input logic [7:0] in_dat, input int in_wait);
    int lat, exp_wr, exp_rd, wr_n, rd_n, n, wcnt, held, old_ptr, new_ptr;
    logic [7:0] cell0;
    old_ptr = ptr; new_ptr = ptr; cell0 = tape[ptr];
    exp_wr = -1; exp_rd = -1; lat = 1;
    case (c)
      3'd1: begin tape[ptr] = 8'((int'(cell0) + 1) % 256); dirty = 1'b1; end
      3'd2: begin tape[ptr] = 8'((int'(cell0) + 255) % 256); dirty = 1'b1; end
      3'd3, 3'd4: begin
        new_ptr = (c == 3'd3) ? (ptr + 1) % (MAXA + 1) : (ptr + MAXA) % (MAXA + 1);
        lat    = dirty ? 4 : 3;
        exp_wr = dirty ? 1 : -1;
        exp_rd = dirty ? 2 : 1;
        dirty  = 1'b0;
      end
      3'd5: lat = out_wait + 2;
      3'd6: begin lat = in_wait + 2; tape[ptr] = in_dat; dirty = 1'b1; end
      3'd7: begin lat = dirty ? 2 : 1; exp_wr = dirty ? 1 : -1; dirty = 1'b0; end
      default: lat = 1;
    endcase
    chk("ready_before", o_cmd_ready, 1);
    i_cmd = c; i_cmd_valid = 1'b1;
    @(posedge i_clock); #1;
    i_cmd_valid = 1'b0;
    n = 1; wr_n = -1; rd_n = -1; wcnt = 0; held = 0;
    while (n < 40) begin
      if (o_mem_wr) begin
        if (wr_n < 0) wr_n = n;
        chk("wr_addr", o_address, old_ptr);
        chk("wr_data", o_mem_wdata, tape[old_ptr]);
      end
      if (o_mem_rd) begin
        if (rd_n < 0) rd_n = n;
        chk("rd_addr", o_address, new_ptr);
      end
      if (o_mem_rd && o_mem_wr) chk("strobe_excl", 1, 0);
      if (o_out_valid) begin
        held++;
        chk("out_data", o_out_data, cell0);
        if (wcnt == out_wait) i_out_ready = 1'b1; else wcnt++;
      end
      if (o_in_ready) begin
        if (wcnt == in_wait) begin i_in_valid = 1'b1; i_in_data = in_dat; end
        else wcnt++;
      end
      if (o_done) break;
      @(posedge i_clock); #1;
      i_out_ready = 1'b0; i_in_valid = 1'b0;
      n++;
    end
    ptr = new_ptr;
    chk("done", o_done, 1);
    chk("done_excl", o_out_valid | o_in_ready, 0);
    chk("latency", n, lat);
    chk("wr_cycle", wr_n, exp_wr);
    chk("rd_cycle", rd_n, exp_rd);
    chk("address", o_address, ptr);
    chk("cell", o_cell, tape[ptr]);
    chk("zero", o_zero, tape[ptr] == 8'd0);
    chk("ready_after", o_cmd_ready, 1);
    if (c == 3'd5) chk("out_held", held, out_wait + 1);
  endtask

  initial begin
    logic [7:0] v;
    int rp;

    // 1: reset release and initial reload of RAM[0]=0x41
    repeat (3) @(posedge i_clock);
    #1 i_rst = 1'b1;
    reset_release_check(1'b1);

    // 3: walk to address 5, dirty move writes back, clean move does not
    for (int i = 0; i < 5; i++) issue(3'd3, 0, 8'd0, 0);
    chk("cell_at_5", o_cell, 8'h07);
    issue(3'd1, 0, 8'd0, 0);
    issue(3'd3, 0, 8'd0, 0);
    chk("ram5_written", mem[5], 8'h08);
    issue(3'd3, 0, 8'd0, 0);

    // 4: pointer wrap both ways
    for (int i = 0; i < 7; i++) issue(3'd4, 0, 8'd0, 0);
    chk("at_zero", o_address, 0);
    issue(3'd4, 0, 8'd0, 0);
    chk("wrap_left", o_address, MAXA);
    issue(3'd3, 0, 8'd0, 0);
    chk("wrap_right", o_address, 0);

    // 2: cell wrap and back-to-back ops
    issue(3'd6, 0, 8'd255, 0);
    issue(3'd1, 0, 8'd0, 0);
    chk("inc_wrap_zero", o_zero, 1);
    issue(3'd2, 0, 8'd0, 0);
    chk("dec_wrap", o_cell, 8'd255);
    i_cmd = 3'd1; i_cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clock); #1;
      tape[ptr] = 8'((int'(tape[ptr]) + 1) % 256);
      chk("b2b_done", o_done, 1);
    end
    i_cmd_valid = 1'b0;
    chk("b2b_cell", o_cell, tape[ptr]);
    @(posedge i_clock); #1;
    chk("b2b_done_drop", o_done, 0);

    // 5: console handshakes and flush
    issue(3'd6, 0, 8'h48, 0);
    issue(3'd5, 3, 8'd0, 0);
    issue(3'd6, 0, 8'h31, 2);
    chk("in_cell", o_cell, 8'h31);
    issue(3'd7, 0, 8'd0, 0);
    chk("flush_ram", mem[ptr], 8'h31);
    issue(3'd7, 0, 8'd0, 0);

    // random command stream
    for (int k = 0; k < 150; k++)
      issue(3'($urandom_range(0, 7)), $urandom_range(0, 3), 8'($urandom), $urandom_range(0, 3));

    // 6: reset lands on the WB cycle of a dirty move
    issue(3'd3, 0, 8'd0, 0);
    issue(3'd7, 0, 8'd0, 0);
    rp = ptr;
    v = tape[ptr];
    issue(3'd1, 0, 8'd0, 0);
    i_cmd = 3'd3; i_cmd_valid = 1'b1;
    @(posedge i_clock); #1;
    i_cmd_valid = 1'b0;
    chk("wb_strobe", o_mem_wr, 1);
    i_rst = 1'b0;
    #1;
    chk("wb_killed", o_mem_wr, 0);
    repeat (2) @(posedge i_clock);
    #1 i_rst = 1'b1;
    chk("no_writeback", mem[rp], v);
    reset_release_check(1'b0);

    for (int k = 0; k < 30; k++)
      issue(3'($urandom_range(0, 7)), $urandom_range(0, 2), 8'($urandom), $urandom_range(0, 2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
